fc_seq_ctrl: RTL and testbench
==============================

Name: fc_seq_ctrl

Overview:
- Consumer-side sequencer for the conv/FC ping-pong activation buffers.
- The conv controller writes one bank (c0~c4 or d0~d4, chosen by mem_sel) and pulses conv_done. This block then reads that bank through FC1 and FC2, generates activation/weight SRAM addresses and accumulator controls, and pulses fc_done when the frame is finished.
- fc_done is what lets the conv-side controller flip mem_sel again. A pending flag absorbs one early conv_done.

Parameters:
FC1_IN_WORDS, 50, activation words read per FC1 neuron (16 activations/word)
FC1_OUT, 500, FC1 output neurons
FC2_IN_WORDS, 32, activation words read per FC2 neuron
FC2_OUT, 10, FC2 output neurons
FC2_ACT_BASE, 64, activation address base of FC1 results (FC2 input)
ADDR_W, 16, address width

Ports:
clk  in  1  clock
srstn  in  1  synchronous active-low reset
conv_done  in  1  one-cycle pulse: conv side finished writing bank mem_sel
mem_sel  in  1  conv-side bank select (0: c0~c4, 1: d0~d4), sampled on conv_done
src_bank  out  1  bank this block reads (0: c0~c4, 1: d0~d4)
rd_en  out  1  activation+weight SRAM read strobe
act_addr  out  ADDR_W  activation read address
wgt_addr  out  ADDR_W  weight read address
acc_en  out  1  accumulate SRAM data this cycle
acc_first  out  1  with acc_en: load instead of add
out_valid  out  1  accumulator holds a finished neuron
out_idx  out  10  neuron index for out_valid
layer  out  1  0: FC1, 1: FC2 (qualifies out_valid)
fc_busy  out  1  frame in progress (state != IDLE)
fc_done  out  1  one-cycle pulse at frame end
overrun  out  1  sticky: conv_done arrived while pending already set

Behaviour:
- Reset (srstn=0 at posedge): state=IDLE; all counters, src_bank, pending, overrun, the delay pipe and every output go to 0. Reset mid-frame aborts it. No fc_done is issued for the aborted frame.
- States: IDLE, FC1, DRAIN1, FC2, DRAIN2, DONE.
- IDLE -> FC1 when conv_done=1 or pending=1.
  - src_bank <= mem_sel sampled in that cycle if conv_done=1.
  - Otherwise src_bank <= the value latched with pending, and pending clears.
- conv_done while state != IDLE:
  - If pending=0: pending<=1 and the bank is latched into the pending slot.
  - If pending=1: overrun<=1 (sticky until reset) and the bank latch is unchanged.
- conv_done in DONE is treated as "not IDLE": it sets pending.
- FC1/FC2 issue phase:
  - rd_en=1 every cycle.
  - in_cnt counts 0..IN_WORDS-1; neu_cnt counts 0..OUT-1 and advances when in_cnt wraps.
  - act_addr = in_cnt in FC1, and FC2_ACT_BASE+in_cnt in FC2.
  - wgt_addr is a free-running counter: 0 on frame start, +1 per read, continuous from FC1 into FC2.
- On the last read (last in_cnt of last neuron), FC1->DRAIN1 or FC2->DRAIN2.
- DRAIN1 and DRAIN2 each last exactly 2 cycles with rd_en=0, then go to FC2 and DONE respectively.
- DONE: fc_done=1 for exactly one cycle, then IDLE.
- Output pipeline (SRAM read latency 1 cycle):
  - acc_en = rd_en delayed 1 cycle.
  - acc_first = (rd_en & in_cnt==0) delayed 1 cycle.
  - out_valid = (rd_en & in_cnt==IN_WORDS-1) delayed 2 cycles.
  - out_idx and layer are the neu_cnt and layer of that read, delayed 2 cycles.
  - The drain window guarantees the last FC1 out_valid occurs before the first FC2 read.
- Frame length in cycles from the FC1 entry cycle through fc_done: FC1_IN_WORDS*FC1_OUT + 2 + FC2_IN_WORDS*FC2_OUT + 2 + 1.
- fc_busy=1 in every state except IDLE.
- Address arithmetic is unsigned modulo 2^ADDR_W.
- IN_WORDS=1 is legal: acc_first and out_valid then fire for every read.

Test Plan:
- Small params (2,3,1,2, base 8). conv_done pulse with mem_sel=1 at cycle 0 -> the following are required:
  - src_bank=1 from cycle 1.
  - rd_en cycles 1-6 with act_addr 0,1,0,1,0,1; rd_en cycles 9-10 with act_addr 8,8.
  - wgt_addr 0..7.
  - fc_done high only at cycle 13.
- Same run, pipeline check:
  - acc_first at cycles 2,4,6,10,11.
  - out_valid at cycles 4,6,8 (layer 0, idx 0,1,2) and at 11,12 (layer 1, idx 0,1).
- conv_done with mem_sel=0 at cycle 5 of a frame -> pending=1, overrun=0. After the first fc_done, IDLE lasts 1 cycle, then FC1 restarts with src_bank=0 and wgt_addr=0.
- Two conv_done pulses during one frame -> overrun=1 and stays 1 through subsequent frames until srstn=0.
- srstn=0 during FC2 -> next cycle all outputs are 0 and state=IDLE, and no fc_done follows. A new conv_done then starts a clean frame.
- Default params: single frame -> exactly 25000+2+320+2+1 = 25325 cycles from FC1 entry to fc_done inclusive; 510 out_valid pulses.

Source files
------------

// File: rtl/fc_seq_ctrl_if.sv
// Bus between the conv-side controller and the FC sequencer: the conv_done
// handshake plus the SRAM address and accumulator control outputs.
interface fc_seq_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              conv_done;
  logic              mem_sel;
  logic              src_bank;
  logic              rd_en;
  logic [ADDR_W-1:0] act_addr;
  logic [ADDR_W-1:0] wgt_addr;
  logic              acc_en;
  logic              acc_first;
  logic              out_valid;
  logic [9:0]        out_idx;
  logic              layer;
  logic              fc_busy;
  logic              fc_done;
  logic              overrun;

  modport master (
    output conv_done, mem_sel,
    input  src_bank, rd_en, act_addr, wgt_addr, acc_en, acc_first,
           out_valid, out_idx, layer, fc_busy, fc_done, overrun
  );

  modport slave (
    input  conv_done, mem_sel,
    output src_bank, rd_en, act_addr, wgt_addr, acc_en, acc_first,
           out_valid, out_idx, layer, fc_busy, fc_done, overrun
  );
endinterface

// File: rtl/fc_seq_ctrl.sv
// FC1/FC2 read sequencer for the ping-pong activation banks: walks the bank
// written by the conv side, drives SRAM addresses and accumulator controls.
module fc_seq_ctrl #(
  parameter int FC1_IN_WORDS = 50,
  parameter int FC1_OUT      = 500,
  parameter int FC2_IN_WORDS = 32,
  parameter int FC2_OUT      = 10,
  parameter int FC2_ACT_BASE = 64,
  parameter int ADDR_W       = 16
) (
  input logic          clk,
  input logic          srstn,
  fc_seq_ctrl_if.slave bus
);
  localparam logic [ADDR_W-1:0] FC1_IN_LAST = ADDR_W'(FC1_IN_WORDS - 1);
  localparam logic [ADDR_W-1:0] FC2_IN_LAST = ADDR_W'(FC2_IN_WORDS - 1);
  localparam logic [ADDR_W-1:0] ACT_BASE    = ADDR_W'(FC2_ACT_BASE);
  localparam logic [9:0]        FC1_N_LAST  = 10'(FC1_OUT - 1);
  localparam logic [9:0]        FC2_N_LAST  = 10'(FC2_OUT - 1);

  typedef enum logic [2:0] {IDLE, FC1, DRAIN1, FC2, DRAIN2, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] in_q, in_d, wgt_q, wgt_d;
  logic [9:0]        neu_q, neu_d;
  logic              drn_q, drn_d;
  logic              bank_q, bank_d, pend_q, pend_d, pbank_q, pbank_d;
  logic              ovr_q, ovr_d;
  // read-latency pipe: stage 1 feeds the accumulator, stage 2 flags results
  logic              acc_en_q, acc_first_q, vl1_q, lay1_q;
  logic [9:0]        idx1_q;
  logic              out_valid_q, layer_q;
  logic [9:0]        out_idx_q;

  logic rd, in_fc2, in_last, neu_last;

  always_comb begin
    state_d  = state_q;
    in_d     = in_q;
    wgt_d    = wgt_q;
    neu_d    = neu_q;
    drn_d    = 1'b0;
    bank_d   = bank_q;
    pend_d   = pend_q;
    pbank_d  = pbank_q;
    ovr_d    = ovr_q;
    in_fc2   = (state_q == FC2);
    rd       = (state_q == FC1) || in_fc2;
    in_last  = in_fc2 ? (in_q == FC2_IN_LAST) : (in_q == FC1_IN_LAST);
    neu_last = in_fc2 ? (neu_q == FC2_N_LAST) : (neu_q == FC1_N_LAST);

    case (state_q)
      IDLE: begin
        if (bus.conv_done || pend_q) begin
          state_d = FC1;
          in_d    = '0;
          neu_d   = '0;
          wgt_d   = '0;
          if (bus.conv_done) begin
            bank_d = bus.mem_sel;
          end else begin
            bank_d = pbank_q;
            pend_d = 1'b0;
          end
        end
      end
      FC1, FC2: begin
        wgt_d = wgt_q + 1'b1;
        if (in_last) begin
          in_d = '0;
          if (neu_last) begin
            neu_d   = '0;
            state_d = in_fc2 ? DRAIN2 : DRAIN1;
          end else begin
            neu_d = neu_q + 1'b1;
          end
        end else begin
          in_d = in_q + 1'b1;
        end
      end
      DRAIN1, DRAIN2: begin
        drn_d = ~drn_q;
        if (drn_q) state_d = (state_q == DRAIN1) ? FC2 : DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // One early frame is queued; a second one while queued is only flagged.
    if (bus.conv_done && state_q != IDLE) begin
      if (!pend_q) begin
        pend_d  = 1'b1;
        pbank_d = bus.mem_sel;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q     <= IDLE;
      in_q        <= '0;
      wgt_q       <= '0;
      neu_q       <= '0;
      drn_q       <= 1'b0;
      bank_q      <= 1'b0;
      pend_q      <= 1'b0;
      pbank_q     <= 1'b0;
      ovr_q       <= 1'b0;
      acc_en_q    <= 1'b0;
      acc_first_q <= 1'b0;
      vl1_q       <= 1'b0;
      lay1_q      <= 1'b0;
      idx1_q      <= '0;
      out_valid_q <= 1'b0;
      layer_q     <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_q        <= in_d;
      wgt_q       <= wgt_d;
      neu_q       <= neu_d;
      drn_q       <= drn_d;
      bank_q      <= bank_d;
      pend_q      <= pend_d;
      pbank_q     <= pbank_d;
      ovr_q       <= ovr_d;
      acc_en_q    <= rd;
      acc_first_q <= rd && (in_q == '0);
      vl1_q       <= rd && in_last;
      lay1_q      <= in_fc2;
      idx1_q      <= neu_q;
      out_valid_q <= vl1_q;
      layer_q     <= lay1_q;
      out_idx_q   <= idx1_q;
    end
  end

  assign bus.src_bank  = bank_q;
  assign bus.rd_en     = rd;
  assign bus.act_addr  = rd ? (in_fc2 ? ACT_BASE + in_q : in_q) : '0;
  assign bus.wgt_addr  = wgt_q;
  assign bus.acc_en    = acc_en_q;
  assign bus.acc_first = acc_first_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.layer     = layer_q;
  assign bus.fc_busy   = (state_q != IDLE);
  assign bus.fc_done   = (state_q == DONE);
  assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Scoreboard bench: small-parameter instance checked cycle by cycle against
// a frame model, default-parameter instance checked for frame length.
module tb_fc_seq_ctrl;
  logic clk = 1'b0;
  logic srstn = 1'b0;
  always #5 clk = ~clk;

  fc_seq_ctrl_if #(.ADDR_W(16)) bs ();
  fc_seq_ctrl_if #(.ADDR_W(16)) bd ();

  fc_seq_ctrl #(.FC1_IN_WORDS(2), .FC1_OUT(3), .FC2_IN_WORDS(1), .FC2_OUT(2),
                .FC2_ACT_BASE(8), .ADDR_W(16))
    dut_s (.clk(clk), .srstn(srstn), .bus(bs));
  fc_seq_ctrl dut_d (.clk(clk), .srstn(srstn), .bus(bd));

  typedef struct {int c; logic [15:0] a; logic [15:0] w; logic b;} rd_t;
  typedef struct {int c; logic l; logic [9:0] i;} ov_t;
  typedef struct {int c; logic m;} cd_t;
  typedef struct {int s; int e;} fr_t;

  rd_t rd_q[$];
  ov_t ov_q[$];
  cd_t cd_q[$];
  fr_t fr_q[$];
  int  acc_q[$], fst_q[$], done_q[$];

  int total = 0, bad = 0;
  int gcyc = 0, rst_at = -1;
  int ovr_on = 1 << 30, ovr_off = 1 << 30;

  task automatic sched_cd(input int c, input logic m);
    cd_t x;
    x.c = c; x.m = m;
    cd_q.push_back(x);
  endtask

  // Expected trace of one frame whose conv_done (or pending restart) is at cycle t.
  task automatic push_frame(input int t, input logic b);
    int c, w, nin, nout, base;
    rd_t r; ov_t o; fr_t f;
    c = t + 1; w = 0;
    for (int ly = 0; ly < 2; ly++) begin
      nin = (ly == 1) ? 1 : 2;
      nout = (ly == 1) ? 2 : 3;
      base = (ly == 1) ? 8 : 0;
      for (int n = 0; n < nout; n++) begin
        for (int i = 0; i < nin; i++) begin
          r.c = c; r.a = 16'(base + i); r.w = 16'(w); r.b = b;
          rd_q.push_back(r);
          acc_q.push_back(c + 1);
          if (i == 0) fst_q.push_back(c + 1);
          if (i == nin - 1) begin
            o.c = c + 2; o.l = (ly == 1); o.i = 10'(n);
            ov_q.push_back(o);
          end
          c++; w++;
        end
      end
      c += 2;
    end
    done_q.push_back(c);
    f.s = t + 1; f.e = c;
    fr_q.push_back(f);
  endtask

  // Drop every expectation after reset cycle r.
  task automatic trunc(input int r);
    while (rd_q.size() > 0 && rd_q[$].c > r) void'(rd_q.pop_back());
    while (ov_q.size() > 0 && ov_q[$].c > r) void'(ov_q.pop_back());
    while (acc_q.size() > 0 && acc_q[$] > r) void'(acc_q.pop_back());
    while (fst_q.size() > 0 && fst_q[$] > r) void'(fst_q.pop_back());
    while (done_q.size() > 0 && done_q[$] > r) void'(done_q.pop_back());
    while (fr_q.size() > 0 && fr_q[$].s > r) void'(fr_q.pop_back());
    if (fr_q.size() > 0 && fr_q[$].e > r) fr_q[$].e = r;
  endtask

  task automatic run_cycles(input int n);
    logic e;
    rd_t r; ov_t o;
    repeat (n) begin
      @(posedge clk); #1;
      gcyc++;
      srstn = (gcyc == rst_at) ? 1'b0 : 1'b1;
      if (cd_q.size() > 0 && cd_q[0].c == gcyc) begin
        bs.conv_done = 1'b1;
        bs.mem_sel = cd_q[0].m;
        void'(cd_q.pop_front());
      end else begin
        bs.conv_done = 1'b0;
      end
      @(negedge clk);
      e = rd_q.size() > 0 && rd_q[0].c == gcyc;
      total++;
      if (bs.rd_en !== e) begin
        bad++; $display("FAIL rd_en cyc=%0d got=%b exp=%b", gcyc, bs.rd_en, e);
      end
      if (e) begin
        r = rd_q.pop_front();
        total += 3;
        if (bs.act_addr !== r.a) begin
          bad++; $display("FAIL act_addr cyc=%0d got=%0d exp=%0d", gcyc, bs.act_addr, r.a);
        end
        if (bs.wgt_addr !== r.w) begin
          bad++; $display("FAIL wgt_addr cyc=%0d got=%0d exp=%0d", gcyc, bs.wgt_addr, r.w);
        end
        if (bs.src_bank !== r.b) begin
          bad++; $display("FAIL src_bank cyc=%0d got=%b exp=%b", gcyc, bs.src_bank, r.b);
        end
      end
      e = acc_q.size() > 0 && acc_q[0] == gcyc;
      if (e) void'(acc_q.pop_front());
      total++;
      if (bs.acc_en !== e) begin
        bad++; $display("FAIL acc_en cyc=%0d got=%b exp=%b", gcyc, bs.acc_en, e);
      end
      e = fst_q.size() > 0 && fst_q[0] == gcyc;
      if (e) void'(fst_q.pop_front());
      total++;
      if (bs.acc_first !== e) begin
        bad++; $display("FAIL acc_first cyc=%0d got=%b exp=%b", gcyc, bs.acc_first, e);
      end
      e = ov_q.size() > 0 && ov_q[0].c == gcyc;
      total++;
      if (bs.out_valid !== e) begin
        bad++; $display("FAIL out_valid cyc=%0d got=%b exp=%b", gcyc, bs.out_valid, e);
      end
      if (e) begin
        o = ov_q.pop_front();
        total++;
        if (bs.out_idx !== o.i || bs.layer !== o.l) begin
          bad++; $display("FAIL out_idx/layer cyc=%0d got=%0d/%b exp=%0d/%b",
                          gcyc, bs.out_idx, bs.layer, o.i, o.l);
        end
      end
      e = done_q.size() > 0 && done_q[0] == gcyc;
      if (e) void'(done_q.pop_front());
      total++;
      if (bs.fc_done !== e) begin
        bad++; $display("FAIL fc_done cyc=%0d got=%b exp=%b", gcyc, bs.fc_done, e);
      end
      e = fr_q.size() > 0 && gcyc >= fr_q[0].s && gcyc <= fr_q[0].e;
      if (fr_q.size() > 0 && gcyc >= fr_q[0].e) void'(fr_q.pop_front());
      total++;
      if (bs.fc_busy !== e) begin
        bad++; $display("FAIL fc_busy cyc=%0d got=%b exp=%b", gcyc, bs.fc_busy, e);
      end
      e = (gcyc >= ovr_on) && (gcyc < ovr_off);
      total++;
      if (bs.overrun !== e) begin
        bad++; $display("FAIL overrun cyc=%0d got=%b exp=%b", gcyc, bs.overrun, e);
      end
    end
  endtask

  task automatic run_to(input int c);
    if (c > gcyc) run_cycles(c - gcyc);
  endtask

  task automatic test_reset;
    logic [50:0] v;
    srstn = 1'b0;
    bs.conv_done = 1'b0; bs.mem_sel = 1'b0;
    bd.conv_done = 1'b0; bd.mem_sel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    v = {bs.src_bank, bs.rd_en, bs.act_addr, bs.wgt_addr, bs.acc_en, bs.acc_first,
         bs.out_valid, bs.out_idx, bs.layer, bs.fc_busy, bs.fc_done, bs.overrun};
    total++;
    if (v !== '0) begin bad++; $display("FAIL reset_outs_s got=%h exp=0", v); end
    v = {bd.src_bank, bd.rd_en, bd.act_addr, bd.wgt_addr, bd.acc_en, bd.acc_first,
         bd.out_valid, bd.out_idx, bd.layer, bd.fc_busy, bd.fc_done, bd.overrun};
    total++;
    if (v !== '0) begin bad++; $display("FAIL reset_outs_d got=%h exp=0", v); end
  endtask

  task automatic test_single_frame;
    int t;
    t = gcyc + 2;
    sched_cd(t, 1'b1);
    push_frame(t, 1'b1);
    run_to(t + 16);
  endtask

  task automatic test_pending;
    int t;
    t = gcyc + 2;
    sched_cd(t, 1'b1);
    sched_cd(t + 5, 1'b0);
    push_frame(t, 1'b1);
    push_frame(t + 14, 1'b0);
    run_to(t + 30);
  endtask

  task automatic test_done_cd;
    int t;
    t = gcyc + 2;
    sched_cd(t, 1'b0);
    sched_cd(t + 13, 1'b1);
    push_frame(t, 1'b0);
    push_frame(t + 14, 1'b1);
    run_to(t + 30);
  endtask

  task automatic test_overrun;
    int t;
    t = gcyc + 2;
    sched_cd(t, 1'b0);
    sched_cd(t + 3, 1'b1);
    sched_cd(t + 5, 1'b0);
    ovr_on = t + 6;
    push_frame(t, 1'b0);
    push_frame(t + 14, 1'b1);
    run_to(t + 30);
    t = gcyc + 3;
    sched_cd(t, 1'b0);
    push_frame(t, 1'b0);
    run_to(t + 16);
  endtask

  task automatic test_mid_reset;
    int t, r;
    logic [50:0] v;
    t = gcyc + 2;
    sched_cd(t, 1'b1);
    push_frame(t, 1'b1);
    r = t + 9;
    rst_at = r;
    ovr_off = r + 1;
    trunc(r);
    run_to(r + 1);
    v = {bs.src_bank, bs.rd_en, bs.act_addr, bs.wgt_addr, bs.acc_en, bs.acc_first,
         bs.out_valid, bs.out_idx, bs.layer, bs.fc_busy, bs.fc_done, bs.overrun};
    total++;
    if (v !== '0) begin bad++; $display("FAIL mid_reset_outs got=%h exp=0", v); end
    run_to(gcyc + 20);
    t = gcyc + 2;
    sched_cd(t, 1'b0);
    push_frame(t, 1'b0);
    run_to(t + 16);
  endtask

  task automatic test_default;
    int cnt, nov, nov2;
    logic done;
    @(posedge clk); #1;
    bd.mem_sel = 1'b1;
    bd.conv_done = 1'b1;
    cnt = 0; nov = 0; nov2 = 0; done = 1'b0;
    while (!done && cnt < 30000) begin
      @(posedge clk); #1;
      bd.conv_done = 1'b0;
      cnt++;
      @(negedge clk);
      if (bd.out_valid) begin
        nov++;
        if (bd.layer) nov2++;
      end
      done = bd.fc_done;
    end
    total++;
    if (!done || cnt != 25325) begin
      bad++; $display("FAIL default_frame_len got=%0d exp=25325", cnt);
    end
    total++;
    if (nov != 510) begin bad++; $display("FAIL default_out_valid got=%0d exp=510", nov); end
    total++;
    if (nov2 != 10) begin bad++; $display("FAIL default_fc2_outs got=%0d exp=10", nov2); end
    total++;
    if (bd.src_bank !== 1'b1) begin
      bad++; $display("FAIL default_src_bank got=%b exp=1", bd.src_bank);
    end
  endtask

  task automatic test_drained;
    int left;
    left = rd_q.size() + ov_q.size() + acc_q.size() + fst_q.size() + done_q.size();
    total++;
    if (left != 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d exp=0", left); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_pending();
    test_done_cd();
    test_overrun();
    test_mid_reset();
    test_drained();
    test_default();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
